// File: rtl/matmul_engine.sv
// matmul_engine: sequential C = A x B for an M x K by K x P pair.
// LANES output columns are accumulated in parallel per pass; operands are
// snapshotted when start is accepted, so A/B may change during the run.
// Build option: define MATMUL_SIGNED_EN for two's-complement operands
// (sign-extended products); the default build is fully unsigned.
module matmul_engine #(
  parameter int M          = 4,
  parameter int K          = 4,
  parameter int P          = 4,
  parameter int DATA_WIDTH = 8,
  parameter int LANES      = 1,
  parameter int ACC_WIDTH  = 2*DATA_WIDTH + $clog2(K)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [DATA_WIDTH-1:0] A [0:M-1][0:K-1],
  input  logic [DATA_WIDTH-1:0] B [0:K-1][0:P-1],
  output logic [ACC_WIDTH-1:0]  C [0:M-1][0:P-1],
  output logic                  busy,
  output logic                  done
);

  localparam int G  = P / LANES;
  localparam int RW = (M > 1) ? $clog2(M) : 1;
  localparam int GW = (G > 1) ? $clog2(G) : 1;
  localparam int KW = (K > 1) ? $clog2(K) : 1;

  if (P % LANES != 0) begin : g_bad_lanes
    $error("matmul_engine: P must be a multiple of LANES");
  end

  typedef enum logic [1:0] {S_IDLE, S_MAC, S_WRITE, S_DONE} state_t;

  state_t          state_q, state_d;
  logic [RW-1:0]   row_q, row_d;
  logic [GW-1:0]   grp_q, grp_d;
  logic [KW-1:0]   k_q, k_d;
  logic            accept;

  logic [DATA_WIDTH-1:0] asnap_q [0:M-1][0:K-1];
  logic [DATA_WIDTH-1:0] bsnap_q [0:K-1][0:P-1];
  logic [ACC_WIDTH-1:0]  acc_q   [0:LANES-1];
  logic [ACC_WIDTH-1:0]  c_q     [0:M-1][0:P-1];

  logic [DATA_WIDTH-1:0] a_sel;
  logic [DATA_WIDTH-1:0] b_sel [0:LANES-1];
  logic [ACC_WIDTH-1:0]  prod  [0:LANES-1];

  // Full-width product of one operand pair, extended (or wrapped) to ACC_WIDTH.
  function automatic logic [ACC_WIDTH-1:0] mul_ext(
    input logic [DATA_WIDTH-1:0] a,
    input logic [DATA_WIDTH-1:0] b
  );
`ifdef MATMUL_SIGNED_EN
    logic signed [2*DATA_WIDTH-1:0]           p;
    logic        [ACC_WIDTH+2*DATA_WIDTH-1:0] w;
    p = $signed(a) * $signed(b);
    w = {{ACC_WIDTH{p[2*DATA_WIDTH-1]}}, p};
`else
    logic [2*DATA_WIDTH-1:0]           p;
    logic [ACC_WIDTH+2*DATA_WIDTH-1:0] w;
    p = a * b;
    w = {{ACC_WIDTH{1'b0}}, p};
`endif
    return w[ACC_WIDTH-1:0];
  endfunction

  assign accept = (state_q == S_IDLE) && start;

  // Control registers: state and the row/group/k walk.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      row_q   <= '0;
      grp_q   <= '0;
      k_q     <= '0;
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      grp_q   <= grp_d;
      k_q     <= k_d;
    end
  end

  // Next-state logic: K MAC edges then one WRITE edge per work unit.
  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    grp_d   = grp_q;
    k_d     = k_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_MAC;
          row_d   = '0;
          grp_d   = '0;
          k_d     = '0;
        end
      end
      S_MAC: begin
        if (k_q == KW'(K-1)) begin
          k_d     = '0;
          state_d = S_WRITE;
        end else begin
          k_d = k_q + 1'b1;
        end
      end
      S_WRITE: begin
        if (grp_q != GW'(G-1)) begin
          grp_d   = grp_q + 1'b1;
          state_d = S_MAC;
        end else if (row_q != RW'(M-1)) begin
          grp_d   = '0;
          row_d   = row_q + 1'b1;
          state_d = S_MAC;
        end else begin
          state_d = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Operand capture on accept; only consumed while busy, so no reset needed.
  always_ff @(posedge clk) begin
    if (accept) begin
      asnap_q <= A;
      bsnap_q <= B;
    end
  end

  // Operand selection for the current row, k and column group, one product per lane.
  always_comb begin
    a_sel = asnap_q[row_q][k_q];
    for (int l = 0; l < LANES; l++) begin
      b_sel[l] = '0;
      for (int g = 0; g < G; g++) begin
        if (grp_q == GW'(g)) b_sel[l] = bsnap_q[k_q][g*LANES+l];
      end
      prod[l] = mul_ext(a_sel, b_sel[l]);
    end
  end

  // Lane accumulators: cleared on accept and after each WRITE, summed in MAC.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int l = 0; l < LANES; l++) acc_q[l] <= '0;
    end else begin
      for (int l = 0; l < LANES; l++) begin
        if (accept || state_q == S_WRITE) acc_q[l] <= '0;
        else if (state_q == S_MAC)        acc_q[l] <= acc_q[l] + prod[l];
      end
    end
  end

  // Result matrix: cleared on accept, one column group stored per WRITE.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < M; i++)
        for (int j = 0; j < P; j++) c_q[i][j] <= '0;
    end else if (accept) begin
      for (int i = 0; i < M; i++)
        for (int j = 0; j < P; j++) c_q[i][j] <= '0;
    end else if (state_q == S_WRITE) begin
      for (int i = 0; i < M; i++)
        for (int j = 0; j < P; j++)
          if (row_q == RW'(i) && grp_q == GW'(j / LANES)) c_q[i][j] <= acc_q[j % LANES];
    end
  end

  assign C    = c_q;
  assign busy = (state_q != S_IDLE);
  assign done = (state_q == S_DONE);

endmodule

// File: tb/tb_matmul_engine.sv
// Self-checking bench for matmul_engine: two configurations (2x3x2 with one
// lane, 4x4x4 with two lanes), directed cases plus random operands checked
// against a plain-arithmetic matrix product.
module tb_matmul_engine;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset;
  logic xstart, ystart;
  logic xbusy, xdone, ybusy, ydone;
  logic [7:0]  xa [0:1][0:2];
  logic [7:0]  xb [0:2][0:1];
  logic [17:0] xc [0:1][0:1];
  logic [7:0]  ya [0:3][0:3];
  logic [7:0]  yb [0:3][0:3];
  logic [17:0] yc [0:3][0:3];

  matmul_engine #(.M(2), .K(3), .P(2), .DATA_WIDTH(8), .LANES(1)) u_x (
    .clk(clk), .reset(reset), .start(xstart), .A(xa), .B(xb),
    .C(xc), .busy(xbusy), .done(xdone));

  matmul_engine #(.M(4), .K(4), .P(4), .DATA_WIDTH(8), .LANES(2)) u_y (
    .clk(clk), .reset(reset), .start(ystart), .A(ya), .B(yb),
    .C(yc), .busy(ybusy), .done(ydone));

  int tests = 0;
  int fails = 0;
  int ma [0:3][0:3];
  int mb [0:3][0:3];

  function automatic int elem(input logic [7:0] v);
`ifdef MATMUL_SIGNED_EN
    return int'($signed(v));
`else
    return int'(v);
`endif
  endfunction

  // Reference: C[i][j] = sum_t A[i][t]*B[t][j], kept modulo 2^18.
  function automatic logic [17:0] model(input int kk, input int i, input int j);
    longint s;
    s = 0;
    for (int t = 0; t < kk; t++) s += longint'(ma[i][t]) * longint'(mb[t][j]);
    return s[17:0];
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk4x(input string tag, input int e00, input int e01, input int e10, input int e11);
    chk({tag, "_c00"}, xc[0][0], 18'(e00));
    chk({tag, "_c01"}, xc[0][1], 18'(e01));
    chk({tag, "_c10"}, xc[1][0], 18'(e10));
    chk({tag, "_c11"}, xc[1][1], 18'(e11));
  endtask

  task automatic run_x(input string tag);
    int cnt;
    bit busy_ok;
    for (int i = 0; i < 2; i++) for (int t = 0; t < 3; t++) ma[i][t] = elem(xa[i][t]);
    for (int t = 0; t < 3; t++) for (int j = 0; j < 2; j++) mb[t][j] = elem(xb[t][j]);
    xstart = 1'b1;
    @(posedge clk);
    @(negedge clk);
    xstart = 1'b0;
    for (int i = 0; i < 2; i++) for (int t = 0; t < 3; t++) xa[i][t] = 8'($urandom);
    for (int t = 0; t < 3; t++) for (int j = 0; j < 2; j++) xb[t][j] = 8'($urandom);
    chk({tag, "_clr"}, xc[1][1], 0);
    cnt = 0;
    busy_ok = 1'b1;
    while (!xdone && cnt < 200) begin
      if (!xbusy) busy_ok = 1'b0;
      @(posedge clk);
      cnt++;
      @(negedge clk);
    end
    chk({tag, "_lat"}, cnt, 16);
    chk({tag, "_busy"}, busy_ok, 1);
    for (int i = 0; i < 2; i++)
      for (int j = 0; j < 2; j++)
        chk($sformatf("%s_c%0d%0d", tag, i, j), xc[i][j], model(3, i, j));
    @(posedge clk);
    @(negedge clk);
    chk({tag, "_done1cyc"}, xdone, 0);
    chk({tag, "_idle"}, xbusy, 0);
    chk({tag, "_hold"}, xc[0][0], model(3, 0, 0));
  endtask

  task automatic run_y(input string tag, input int poke);
    int cnt;
    bit busy_ok;
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++) begin
        ma[i][j] = elem(ya[i][j]);
        mb[i][j] = elem(yb[i][j]);
      end
    ystart = 1'b1;
    @(posedge clk);
    @(negedge clk);
    ystart = 1'b0;
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++) begin
        ya[i][j] = 8'($urandom);
        yb[i][j] = 8'($urandom);
      end
    chk({tag, "_clr"}, yc[3][3], 0);
    cnt = 0;
    busy_ok = 1'b1;
    while (!ydone && cnt < 200) begin
      if (!ybusy) busy_ok = 1'b0;
      ystart = (cnt == poke);
      @(posedge clk);
      cnt++;
      @(negedge clk);
    end
    ystart = 1'b0;
    chk({tag, "_lat"}, cnt, 40);
    chk({tag, "_busy"}, busy_ok, 1);
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++)
        chk($sformatf("%s_c%0d%0d", tag, i, j), yc[i][j], model(4, i, j));
    @(posedge clk);
    @(negedge clk);
    chk({tag, "_done1cyc"}, ydone, 0);
    chk({tag, "_idle"}, ybusy, 0);
  endtask

  initial begin
    reset  = 1'b1;
    xstart = 1'b0;
    ystart = 1'b0;
    for (int i = 0; i < 2; i++) for (int t = 0; t < 3; t++) xa[i][t] = '0;
    for (int t = 0; t < 3; t++) for (int j = 0; j < 2; j++) xb[t][j] = '0;
    for (int i = 0; i < 4; i++) for (int j = 0; j < 4; j++) begin ya[i][j] = '0; yb[i][j] = '0; end
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_xc", xc[1][0], 0);
    chk("rst_yc", yc[2][3], 0);
    chk("rst_busy", {xbusy, ybusy}, 0);
    chk("rst_done", {xdone, ydone}, 0);
    reset = 1'b0;
    @(negedge clk);

    // 2x2 example padded with a zero inner term
    xa = '{'{8'd1, 8'd2, 8'd0}, '{8'd3, 8'd4, 8'd0}};
    xb = '{'{8'd5, 8'd6}, '{8'd7, 8'd8}, '{8'd0, 8'd0}};
    run_x("x22");
    chk4x("x22k", 19, 22, 43, 50);

    // 2x3 by 3x2, started in the idle cycle right after the previous done
    xa = '{'{8'd1, 8'd2, 8'd3}, '{8'd4, 8'd5, 8'd6}};
    xb = '{'{8'd7, 8'd8}, '{8'd9, 8'd10}, '{8'd11, 8'd12}};
    run_x("x23");
    chk4x("x23k", 58, 64, 139, 154);

    // negative bit patterns
    xa = '{'{8'hFF, 8'd2, 8'd0}, '{8'd3, 8'hFC, 8'd0}};
    xb = '{'{8'hFB, 8'd6}, '{8'd7, 8'hF8}, '{8'd0, 8'd0}};
    run_x("xsg");
`ifdef MATMUL_SIGNED_EN
    chk4x("xsgk", 19, -22, -43, 50);
`else
    chk4x("xsgk", 64019, 2026, 2517, 62514);
`endif

    // all-ones operands at K=4, with stray starts while busy
    for (int i = 0; i < 4; i++) for (int j = 0; j < 4; j++) begin ya[i][j] = 8'hFF; yb[i][j] = 8'hFF; end
    run_y("ymax", 17);
`ifdef MATMUL_SIGNED_EN
    chk("ymax_k", yc[3][3], 4);
`else
    chk("ymax_k", yc[3][3], 260100);
`endif

    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < 4; i++) for (int j = 0; j < 4; j++) begin ya[i][j] = 8'($urandom); yb[i][j] = 8'($urandom); end
      run_y($sformatf("yrnd%0d", r), (r == 0) ? 3 : 38);
    end

    // reset during the MAC phase of the third work unit
    for (int i = 0; i < 4; i++) for (int j = 0; j < 4; j++) begin ya[i][j] = 8'($urandom_range(255, 1)); yb[i][j] = 8'($urandom_range(255, 1)); end
    ystart = 1'b1;
    @(posedge clk);
    @(negedge clk);
    ystart = 1'b0;
    repeat (11) @(posedge clk);
    @(negedge clk);
    chk("abort_pre_busy", ybusy, 1);
    chk("abort_pre_c00", (yc[0][0] != 0), 1);
    reset = 1'b1;
    #1;
    chk("abort_busy", ybusy, 0);
    chk("abort_done", ydone, 0);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 4; i++) for (int j = 0; j < 4; j++) chk($sformatf("abort_c%0d%0d", i, j), yc[i][j], 0);
    @(negedge clk);
    run_y("ypost", -1);

    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < 2; i++) for (int t = 0; t < 3; t++) xa[i][t] = 8'($urandom);
      for (int t = 0; t < 3; t++) for (int j = 0; j < 2; j++) xb[t][j] = 8'($urandom);
      run_x($sformatf("xrnd%0d", r));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
